serial_fifo_bridge: RTL and testbench

- Sits directly downstream of the data memory's serial ports. Buffers bytes between the CPU's memory-mapped serial interface and an external host byte stream.
- Contains two FIFOs:
  - RX path (host -> CPU): drives the datapath's serial_in / serial_valid_in.
  - TX path (CPU -> host): captures serial_out on serial_wren_out and is drained by the host with a valid/ready handshake.
- Also provides occupancy counts and sticky error flags for debug.

---
 rtl/serial_bridge_pkg.sv | 9 +
 rtl/serial_fifo_bridge_sync_fifo.sv | 85 ++++++++
 rtl/serial_fifo_bridge.sv | 101 ++++++++++
 tb/tb_serial_fifo_bridge.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bridge_pkg.sv
// Shared constants for the serial FIFO bridge.
//   SERIAL_DATA_W     : byte width carried on both directions
//   SERIAL_DEPTH_LOG2 : default log2 of the entries held by each FIFO
package serial_bridge_pkg;

    localparam int SERIAL_DATA_W     = 8;
    localparam int SERIAL_DEPTH_LOG2 = 4;

endpackage

// File: rtl/serial_fifo_bridge_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Ports:
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   push, push_data : write request and byte (ignored while full)
//   pop             : read request (ignored while empty)
//   head_data       : oldest stored byte, forced to zero while empty
//   full, empty     : status derived from the registered occupancy
//   count           : occupancy, 0..2**DEPTH_LOG2
module sync_fifo
    import serial_bridge_pkg::*;
#(
    parameter int DATA_W     = SERIAL_DATA_W,
    parameter int DEPTH_LOG2 = SERIAL_DEPTH_LOG2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   ZERO_COUNT = {(DEPTH_LOG2 + 1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1'b1);

    logic [DATA_W-1:0]     mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_r;
    logic [DEPTH_LOG2-1:0] rptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    // Status comes from the start-of-cycle count only, so a pop never frees
    // room for a push in the same cycle and a push never feeds a same-cycle pop.
    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == ZERO_COUNT);
    assign count     = count_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Show-ahead head byte, zeroed while empty so stale storage never leaks.
    always_comb begin
        head_data = {DATA_W{1'b0}};
        if (empty) begin
            head_data = {DATA_W{1'b0}};
        end else begin
            head_data = mem_r[rptr_r];
        end
    end

    // Storage array; contents need no reset since the empty flag masks them.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at 2**DEPTH_LOG2.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_r  <= {DEPTH_LOG2{1'b0}};
            rptr_r  <= {DEPTH_LOG2{1'b0}};
            count_r <= ZERO_COUNT;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/serial_fifo_bridge.sv
// serial_fifo_bridge: buffers bytes between the CPU memory-mapped serial port
// and an external host byte stream.
// Ports:
//   cpu_rdata_out/cpu_valid_out/cpu_rden_in : RX head towards the CPU, pop on rden
//   cpu_wdata_in/cpu_wren_in/cpu_ready_out  : CPU bytes into the TX FIFO
//   host_in_*                               : host bytes into the RX FIFO (valid/ready)
//   host_out_*                              : TX head towards the host (valid/ready)
//   rx_count_out/tx_count_out               : FIFO occupancies
//   rx_underflow_out/tx_overflow_out        : sticky CPU-side misuse flags
//   clear_flags_in                          : synchronous clear of both flags
module serial_fifo_bridge
    import serial_bridge_pkg::*;
#(
    parameter int DATA_W     = SERIAL_DATA_W,
    parameter int DEPTH_LOG2 = SERIAL_DEPTH_LOG2
) (
    input  logic                clock,
    input  logic                reset,
    output logic [DATA_W-1:0]   cpu_rdata_out,
    output logic                cpu_valid_out,
    input  logic                cpu_rden_in,
    input  logic [DATA_W-1:0]   cpu_wdata_in,
    input  logic                cpu_wren_in,
    output logic                cpu_ready_out,
    input  logic [DATA_W-1:0]   host_in_data,
    input  logic                host_in_valid,
    output logic                host_in_ready,
    output logic [DATA_W-1:0]   host_out_data,
    output logic                host_out_valid,
    input  logic                host_out_ready,
    output logic [DEPTH_LOG2:0] rx_count_out,
    output logic [DEPTH_LOG2:0] tx_count_out,
    output logic                rx_underflow_out,
    output logic                tx_overflow_out,
    input  logic                clear_flags_in
);

    logic rx_full_s;
    logic rx_empty_s;
    logic tx_full_s;
    logic tx_empty_s;
    logic rx_underflow_r;
    logic tx_overflow_r;

    // Host -> CPU buffer.
    sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (host_in_valid && host_in_ready),
        .push_data (host_in_data),
        .pop       (cpu_rden_in),
        .head_data (cpu_rdata_out),
        .full      (rx_full_s),
        .empty     (rx_empty_s),
        .count     (rx_count_out)
    );

    // CPU -> host buffer; the CPU has no back-pressure, so writes while full drop.
    sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (cpu_wren_in),
        .push_data (cpu_wdata_in),
        .pop       (host_out_valid && host_out_ready),
        .head_data (host_out_data),
        .full      (tx_full_s),
        .empty     (tx_empty_s),
        .count     (tx_count_out)
    );

    assign cpu_valid_out    = !rx_empty_s;
    assign host_in_ready    = !rx_full_s;
    assign cpu_ready_out    = !tx_full_s;
    assign host_out_valid   = !tx_empty_s;
    assign rx_underflow_out = rx_underflow_r;
    assign tx_overflow_out  = tx_overflow_r;

    // Sticky flags: a new offence outranks a clear arriving in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_underflow_r <= 1'b0;
            tx_overflow_r  <= 1'b0;
        end else begin
            if (cpu_rden_in && rx_empty_s) begin
                rx_underflow_r <= 1'b1;
            end else if (clear_flags_in) begin
                rx_underflow_r <= 1'b0;
            end else begin
                rx_underflow_r <= rx_underflow_r;
            end
            if (cpu_wren_in && tx_full_s) begin
                tx_overflow_r <= 1'b1;
            end else if (clear_flags_in) begin
                tx_overflow_r <= 1'b0;
            end else begin
                tx_overflow_r <= tx_overflow_r;
            end
        end
    end

endmodule

// File: tb/tb_serial_fifo_bridge.sv
// Self-checking bench for serial_fifo_bridge: directed scenarios followed by
// random traffic, compared every cycle against a queue-based reference model.
module tb_serial_fifo_bridge;

    localparam int DW    = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] cpu_rdata_out;
    logic          cpu_valid_out;
    logic          cpu_rden_in = 1'b0;
    logic [DW-1:0] cpu_wdata_in = 8'h00;
    logic          cpu_wren_in = 1'b0;
    logic          cpu_ready_out;
    logic [DW-1:0] host_in_data = 8'h00;
    logic          host_in_valid = 1'b0;
    logic          host_in_ready;
    logic [DW-1:0] host_out_data;
    logic          host_out_valid;
    logic          host_out_ready = 1'b0;
    logic [DL2:0]  rx_count_out;
    logic [DL2:0]  tx_count_out;
    logic          rx_underflow_out;
    logic          tx_overflow_out;
    logic          clear_flags_in = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: plain queues plus two flag bits.
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] tx_q[$];
    bit            m_uf = 1'b0;
    bit            m_of = 1'b0;

    serial_fifo_bridge dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_rdata_out    (cpu_rdata_out),
        .cpu_valid_out    (cpu_valid_out),
        .cpu_rden_in      (cpu_rden_in),
        .cpu_wdata_in     (cpu_wdata_in),
        .cpu_wren_in      (cpu_wren_in),
        .cpu_ready_out    (cpu_ready_out),
        .host_in_data     (host_in_data),
        .host_in_valid    (host_in_valid),
        .host_in_ready    (host_in_ready),
        .host_out_data    (host_out_data),
        .host_out_valid   (host_out_valid),
        .host_out_ready   (host_out_ready),
        .rx_count_out     (rx_count_out),
        .tx_count_out     (tx_count_out),
        .rx_underflow_out (rx_underflow_out),
        .tx_overflow_out  (tx_overflow_out),
        .clear_flags_in   (clear_flags_in)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model's view of the current state.
    task automatic check_all();
        int rn;
        int tn;
        rn = rx_q.size();
        tn = tx_q.size();
        chk("rx_count", 32'(rx_count_out), 32'(rn));
        chk("tx_count", 32'(tx_count_out), 32'(tn));
        chk("cpu_valid", 32'(cpu_valid_out), 32'(rn != 0));
        chk("cpu_rdata", 32'(cpu_rdata_out), (rn != 0) ? 32'(rx_q[0]) : 32'd0);
        chk("host_out_valid", 32'(host_out_valid), 32'(tn != 0));
        chk("host_out_data", 32'(host_out_data), (tn != 0) ? 32'(tx_q[0]) : 32'd0);
        chk("host_in_ready", 32'(host_in_ready), 32'(rn < DEPTH));
        chk("cpu_ready", 32'(cpu_ready_out), 32'(tn < DEPTH));
        chk("rx_underflow", 32'(rx_underflow_out), 32'(m_uf));
        chk("tx_overflow", 32'(tx_overflow_out), 32'(m_of));
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int  rn;
        int  tn;
        bit  rx_push;
        bit  rx_pop;
        bit  tx_push;
        bit  tx_pop;
        rn      = rx_q.size();
        tn      = tx_q.size();
        rx_push = host_in_valid && (rn < DEPTH);
        rx_pop  = cpu_rden_in && (rn > 0);
        tx_push = cpu_wren_in && (tn < DEPTH);
        tx_pop  = host_out_ready && (tn > 0);
        if (cpu_rden_in && rn == 0) m_uf = 1'b1;
        else if (clear_flags_in)    m_uf = 1'b0;
        if (cpu_wren_in && tn == DEPTH) m_of = 1'b1;
        else if (clear_flags_in)        m_of = 1'b0;
        if (rx_pop)  void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(host_in_data);
        if (tx_pop)  void'(tx_q.pop_front());
        if (tx_push) tx_q.push_back(cpu_wdata_in);
    endtask

    task automatic cyc();
        check_all();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_rden_in    = 1'b0;
        cpu_wren_in    = 1'b0;
        host_in_valid  = 1'b0;
        host_out_ready = 1'b0;
        clear_flags_in = 1'b0;
    endtask

    function automatic bit rbit(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    initial begin
        // Reset state while reset is held.
        #12;
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc();

        // Host pushes three bytes; CPU pops them.
        host_in_valid = 1'b1;
        for (int b = 8'h41; b <= 8'h43; b++) begin
            host_in_data = 8'(b);
            cyc();
        end
        host_in_valid = 1'b0;
        chk("rx_three_count", 32'(rx_count_out), 32'd3);
        chk("rx_three_head", 32'(cpu_rdata_out), 32'h41);
        cpu_rden_in = 1'b1;
        repeat (3) cyc();
        cpu_rden_in = 1'b0;
        chk("rx_drained_valid", 32'(cpu_valid_out), 32'd0);
        chk("rx_drained_data", 32'(cpu_rdata_out), 32'd0);
        cyc();

        // Seventeen CPU writes into a 16-entry TX FIFO.
        cpu_wren_in = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cpu_wdata_in = 8'(i);
            cyc();
        end
        cpu_wren_in = 1'b0;
        chk("tx_full_count", 32'(tx_count_out), 32'd16);
        chk("tx_full_ready", 32'(cpu_ready_out), 32'd0);
        chk("tx_overflow_set", 32'(tx_overflow_out), 32'd1);
        host_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("tx_drain_byte", 32'(host_out_data), 32'(i));
            cyc();
        end
        chk("tx_drain_empty", 32'(host_out_valid), 32'd0);
        host_out_ready = 1'b0;
        clear_flags_in = 1'b1;
        cyc();
        clear_flags_in = 1'b0;
        cyc();

        // Underflow: CPU pops an empty RX while the host pushes.
        host_in_valid = 1'b1;
        host_in_data  = 8'h5A;
        cpu_rden_in   = 1'b1;
        cyc();
        idle_inputs();
        chk("uf_flag", 32'(rx_underflow_out), 32'd1);
        chk("uf_count", 32'(rx_count_out), 32'd1);
        chk("uf_data", 32'(cpu_rdata_out), 32'h5A);
        cpu_rden_in = 1'b1;
        cyc();
        idle_inputs();

        // TX full: host pop and CPU write 0xAA in the same cycle.
        cpu_wren_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cpu_wdata_in = 8'(8'h80 + i);
            cyc();
        end
        cpu_wdata_in   = 8'hAA;
        host_out_ready = 1'b1;
        cyc();
        idle_inputs();
        chk("full_pp_count", 32'(tx_count_out), 32'd15);
        chk("full_pp_overflow", 32'(tx_overflow_out), 32'd1);
        clear_flags_in = 1'b1;
        cyc();
        clear_flags_in = 1'b0;
        chk("clear_overflow", 32'(tx_overflow_out), 32'd0);
        chk("clear_underflow", 32'(rx_underflow_out), 32'd0);
        host_out_ready = 1'b1;
        repeat (16) cyc();
        idle_inputs();

        // Wrap-around: prime 3 bytes then stream 40 with concurrent pop.
        host_in_valid = 1'b1;
        for (int i = 0; i < 43; i++) begin
            host_in_data = 8'(8'hC0 + i);
            cpu_rden_in  = (i >= 3);
            cyc();
            if (i >= 3) chk("wrap_count", 32'(rx_count_out), 32'd3);
        end
        host_in_valid = 1'b0;
        repeat (4) cyc();
        idle_inputs();

        // Mid-stream asynchronous reset with 5 bytes in each FIFO.
        cpu_rden_in = 1'b1;
        cyc();
        cpu_rden_in   = 1'b0;
        host_in_valid = 1'b1;
        cpu_wren_in   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_in_data = 8'(8'h10 + i);
            cpu_wdata_in = 8'(8'h20 + i);
            cyc();
        end
        idle_inputs();
        check_all();
        #2;
        reset = 1'b1;
        #1;
        rx_q.delete();
        tx_q.delete();
        m_uf = 1'b0;
        m_of = 1'b0;
        chk("rst_rx_count", 32'(rx_count_out), 32'd0);
        chk("rst_tx_count", 32'(tx_count_out), 32'd0);
        chk("rst_flags", 32'({rx_underflow_out, tx_overflow_out}), 32'd0);
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_ready", 32'({host_in_ready, cpu_ready_out}), 32'd3);
        cyc();

        // Random traffic in phases with differing push/pop bias.
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 150; n++) begin
                host_in_valid  = rbit((ph == 1) ? 90 : 50);
                host_in_data   = 8'($urandom);
                cpu_rden_in    = rbit((ph == 1) ? 20 : ((ph == 2) ? 85 : 50));
                cpu_wren_in    = rbit((ph == 1) ? 90 : 50);
                cpu_wdata_in   = 8'($urandom);
                host_out_ready = rbit((ph == 1) ? 20 : ((ph == 2) ? 85 : 50));
                clear_flags_in = rbit(8);
                cyc();
            end
        end
        idle_inputs();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
